alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational ALU (bit-slice array, 3-bit op select) between
//   two requesters. Arbitrates round-robin, latches the winner's operands,
//   drives the ALU for one cycle, registers the result and returns it tagged
//   with the requester id. Sits between the two issue ports and the shared ALU.
// PARAMETERS
//   WIDTH  32  operand/result width; must match the shared ALU width
// PORTS
//   clk           in   1      clock; all state updates on rising edge
//   reset         in   1      synchronous, active-high reset
//   req0_valid    in   1      requester 0 has an operation
//   req0_ready    out  1      arbiter accepts requester 0 this cycle
//   req0_op       in   3      op: 0 ADD 1 SUB 2 XOR 3 SLT 4 AND 5 NAND 6 NOR 7 OR
//   req0_a        in   WIDTH  operand A
//   req0_b        in   WIDTH  operand B
//   req1_valid/req1_ready/req1_op/req1_a/req1_b  same as requester 0
//   alu_op        out  3      op select to shared ALU
//   alu_a         out  WIDTH  operand A to shared ALU
//   alu_b         out  WIDTH  operand B to shared ALU
//   alu_result    in   WIDTH  ALU result (combinational from alu_* outputs)
//   alu_carryout  in   1      ALU carry out
//   alu_overflow  in   1      ALU overflow
//   alu_zero      in   1      ALU result == 0
//   rsp_valid     out  1      response held valid
//   rsp_ready     in   1      consumer takes response
//   rsp_id        out  1      requester that issued the op
//   rsp_result    out  WIDTH  registered alu_result
//   rsp_flags     out  3      {carryout, overflow, zero} registered
// BEHAVIOUR
//   - FSM states: IDLE, EXEC, RESP. Reset -> IDLE; reset wins over all events,
//     including mid-EXEC/RESP; in-flight op is discarded, no response emitted.
//   - Reset values: req*_ready=0 during reset cycle, rsp_valid=0, rsp_id=0,
//     rsp_result=0, rsp_flags=0, alu_op/a/b=0, last_grant=1.
//   - req*_ready is combinational, asserted only in IDLE and only for the
//     granted requester; at most one ready high per cycle. Ready does not wait
//     on valid for the granted side except as below.
//   - Grant in IDLE: only one valid -> that one; both valid -> requester
//     !last_grant; none valid -> ready given to !last_grant. First tie after
//     reset goes to requester 0.
//   - Accept = valid && ready in IDLE: latch op/a/b into operand regs, set
//     rsp_id and last_grant to winner, go EXEC. No accept -> stay IDLE.
//   - EXEC (1 cycle): alu_op/a/b driven from operand regs (registered, stable
//     whole cycle). At end of cycle capture alu_result and flags; go RESP.
//   - RESP: rsp_valid=1; rsp_* stable until rsp_ready. On rsp_ready -> IDLE.
//     No new accept in the cycle rsp_ready is seen (ready only in IDLE).
//   - Latency: accept at cycle N -> rsp_valid at N+2. Max throughput one op
//     per 3 cycles with rsp_ready tied high.
//   - alu_* outputs hold last values outside EXEC (no toggling when idle).
//   - Arithmetic semantics belong to the ALU; block never modifies data. SUB
//     and SLT carry-in/invert handling is the ALU's, selected by op only.
//   - Requester dropping valid before accept is legal; no state is kept.
// TESTING
//   1 reset, req0 ADD a=5 b=7 -> accept cycle 0, rsp_valid cycle 2, id=0,
//     result=12, flags=000.
//   2 req0 and req1 valid together from reset, repeated 4 ops each -> grant
//     order 0,1,0,1,0,1,0,1; never both ready in one cycle.
//   3 req1 SUB a=3 b=3, rsp_ready held low 5 cycles -> rsp_valid stays 1,
//     result=0, zero flag=1, rsp stable; req0 ready stays 0 throughout.
//   4 req0 SLT a=-1 b=1 (WIDTH 32) -> result=1; req1 XOR a=32'hFFFF0000
//     b=32'h0F0F0F0F -> result=32'hF0F00F0F.
//   5 reset asserted in EXEC, then in RESP -> next cycle IDLE, rsp_valid=0,
//     all rsp_* = 0, next tie grants requester 0.
//   6 req0 ADD a=32'h7FFFFFFF b=1 -> result=32'h80000000, overflow=1,
//     carryout=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Accepted op runs on the ALU for one cycle; the result is held until taken.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arbState;

    arbState state;
    arbState nextState;
    logic    lastGrant;
    logic    grant;
    logic    accept;

    // Ties and the no-request case both favour the side not served last.
    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (req0_valid && !req1_valid): grant = 1'b0;
            (req1_valid && !req0_valid): grant = 1'b1;
            default:                     grant = !lastGrant;
        endcase
    end

    always_comb begin
        nextState  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = !reset && !grant;
                req1_ready = !reset && grant;
                accept     = !reset && (grant ? req1_valid : req0_valid);
                if (accept) begin
                    nextState = EXEC;
                end
            end
            EXEC: nextState = RESP;
            RESP: begin
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    assign rsp_valid = (state == RESP);

    // Operand registers drive the ALU directly, so it only sees changes on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_id     <= 1'b0;
            lastGrant  <= 1'b1;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                alu_op    <= grant ? req1_op : req0_op;
                alu_a     <= grant ? req1_a : req0_a;
                alu_b     <= grant ? req1_b : req0_b;
                rsp_id    <= grant;
                lastGrant <= grant;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_carryout, alu_overflow, alu_zero};
            end
        end
    end

endmodule
